cv32e40p_div_arbiter: RTL

// - Shares one serial divider (cv32e40p_alu_div) between NUM_REQ requesters with round-robin arbitration.
// - Per request: latches operands, derives the divider side inputs (OpBShift, OpBIsZero, OpBSign), issues one

---
 rtl/cv32e40p_div_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/cv32e40p_div_arbiter.sv
// cv32e40p_div_arbiter: shares one serial divider between NUM_REQ requesters.
// Round-robin grant in IDLE, one operation in flight (IDLE -> ISSUE -> BUSY -> RESP).
// Operands and the divider side inputs (shift, zero, sign) are registered at grant.
// Optional macro DIV_ARB_ZERO_BYPASS_EN: a divisor of zero skips the divider and
// answers directly from RESP (div/udiv -> all ones, rem/urem -> dividend).
module cv32e40p_div_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int C_WIDTH     = 32,
    parameter int C_LOG_WIDTH = 6
) (
    input  logic                         Clk_CI,
    input  logic                         Rst_RBI,
    input  logic [NUM_REQ-1:0]           ReqVld_SI,
    output logic [NUM_REQ-1:0]           ReqGnt_SO,
    input  logic [NUM_REQ*C_WIDTH-1:0]   ReqOpA_DI,
    input  logic [NUM_REQ*C_WIDTH-1:0]   ReqOpB_DI,
    input  logic [NUM_REQ*2-1:0]         ReqOpCode_DI,
    output logic [NUM_REQ-1:0]           RspVld_SO,
    input  logic [NUM_REQ-1:0]           RspRdy_SI,
    output logic [C_WIDTH-1:0]           Rsp_DO,
    output logic [C_WIDTH-1:0]           DivOpA_DO,
    output logic [C_WIDTH-1:0]           DivOpB_DO,
    output logic [C_LOG_WIDTH-1:0]       DivOpBShift_DO,
    output logic                         DivOpBIsZero_SO,
    output logic                         DivOpBSign_SO,
    output logic [1:0]                   DivOpCode_SO,
    output logic                         DivInVld_SO,
    input  logic                         DivOutVld_SI,
    output logic                         DivOutRdy_SO,
    input  logic [C_WIDTH-1:0]           DivRes_DI
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, BUSY, RESP} state_t;

    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   win;
    logic               any_vld;
    logic [C_WIDTH-1:0] sel_a;
    logic [C_WIDTH-1:0] sel_b;
    logic [1:0]         sel_op;
    logic               bypass;

    // Signed ops: length of the sign run below the MSB. Unsigned ops: lzc+1.
    // A zero divisor always maps to C_WIDTH-1.
    function automatic logic [C_LOG_WIDTH-1:0] calc_shift(input logic [C_WIDTH-1:0] b,
                                                          input logic sgn);
        logic [C_LOG_WIDTH-1:0] cnt;
        logic                   run;
        cnt = '0;
        run = 1'b1;
        if (sgn) begin
            for (int i = C_WIDTH-2; i >= 0; i--) begin
                if (run && (b[i] == b[C_WIDTH-1])) cnt = cnt + C_LOG_WIDTH'(1);
                else                               run = 1'b0;
            end
        end else begin
            for (int i = C_WIDTH-1; i >= 0; i--) begin
                if (run && !b[i]) cnt = cnt + C_LOG_WIDTH'(1);
                else              run = 1'b0;
            end
            cnt = cnt + C_LOG_WIDTH'(1);
        end
        if (b == '0) cnt = C_LOG_WIDTH'(C_WIDTH-1);
        return cnt;
    endfunction

    // Round-robin pick: first valid requester at or after ptr+1, plus its operands.
    always_comb begin
        int idx;
        idx     = 0;
        win     = ptr;
        any_vld = 1'b0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!any_vld && ReqVld_SI[idx]) begin
                any_vld = 1'b1;
                win     = PTR_W'(idx);
            end
        end
        sel_a  = ReqOpA_DI[int'(win)*C_WIDTH +: C_WIDTH];
        sel_b  = ReqOpB_DI[int'(win)*C_WIDTH +: C_WIDTH];
        sel_op = ReqOpCode_DI[int'(win)*2 +: 2];
`ifdef DIV_ARB_ZERO_BYPASS_EN
        bypass = (sel_b == '0);
`else
        bypass = 1'b0;
`endif
    end

    assign ReqGnt_SO    = (state == IDLE && any_vld) ? (NUM_REQ'(1) << win) : '0;
    assign DivOutRdy_SO = (state == BUSY) & DivOutVld_SI;

    // Control FSM with registered divider operands, issue pulse and response.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            state           <= IDLE;
            ptr             <= PTR_W'(NUM_REQ-1);
            owner           <= '0;
            DivOpA_DO       <= '0;
            DivOpB_DO       <= '0;
            DivOpBShift_DO  <= '0;
            DivOpBIsZero_SO <= 1'b0;
            DivOpBSign_SO   <= 1'b0;
            DivOpCode_SO    <= 2'b00;
            DivInVld_SO     <= 1'b0;
            RspVld_SO       <= '0;
            Rsp_DO          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_vld) begin
                        ptr   <= win;
                        owner <= win;
                        if (bypass) begin
                            // Zero divisor answered locally; divider registers untouched.
                            Rsp_DO    <= sel_op[1] ? sel_a : '1;
                            RspVld_SO <= NUM_REQ'(1) << win;
                            state     <= RESP;
                        end else begin
                            DivOpA_DO       <= sel_a;
                            DivOpB_DO       <= sel_b;
                            DivOpCode_SO    <= sel_op;
                            DivOpBIsZero_SO <= (sel_b == '0);
                            DivOpBSign_SO   <= sel_op[0] & sel_b[C_WIDTH-1];
                            DivOpBShift_DO  <= calc_shift(sel_b, sel_op[0]);
                            DivInVld_SO     <= 1'b1;
                            state           <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    DivInVld_SO <= 1'b0;
                    state       <= BUSY;
                end
                BUSY: begin
                    if (DivOutVld_SI) begin
                        Rsp_DO    <= DivRes_DI;
                        RspVld_SO <= NUM_REQ'(1) << owner;
                        state     <= RESP;
                    end
                end
                RESP: begin
                    if (RspRdy_SI[owner]) begin
                        RspVld_SO <= '0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
